// File: rtl/sap_pkg.sv
// Shared constants, opcode map and ALU operation encoding for the SAP-1 datapath.
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  // Opcode nibble values carried in IR[7:4].
  localparam logic [3:0] LDA = 4'h1;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] SUB = 4'h3;
  localparam logic [3:0] OUT = 4'h4;
  localparam logic [3:0] XOR = 4'h5;
  localparam logic [3:0] AND = 4'h6;
  localparam logic [3:0] OR  = 4'h7;
  localparam logic [3:0] CMP = 4'h8;
  localparam logic [3:0] LDI = 4'h9;
  localparam logic [3:0] STI = 4'hA;
  localparam logic [3:0] HLT = 4'hF;

  // ALU operations listed from highest to lowest select priority.
  typedef enum logic [2:0] {
    ALU_SUB,
    ALU_XOR,
    ALU_AND,
    ALU_OR,
    ALU_CMP,
    ALU_LDI,
    ALU_STI,
    ALU_ADD
  } alu_op_t;

  // Resolves the one-hot-ish select strobes to a single operation by priority.
  function automatic alu_op_t alu_select(
    input logic sub_add,
    input logic xor_ratna,
    input logic and_ratna,
    input logic or_ratna,
    input logic cmp_ratna,
    input logic lda_imm,
    input logic sta_imm
  );
    if (sub_add)        return ALU_SUB;
    else if (xor_ratna) return ALU_XOR;
    else if (and_ratna) return ALU_AND;
    else if (or_ratna)  return ALU_OR;
    else if (cmp_ratna) return ALU_CMP;
    else if (lda_imm)   return ALU_LDI;
    else if (sta_imm)   return ALU_STI;
    else                return ALU_ADD;
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational ALU: A is the accumulator, B the B register, imm the
// zero-extended IR operand. Carry on subtract/compare means "no borrow".
module sap_alu
  import sap_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  input  logic         sub_add,
  input  logic         xor_ratna,
  input  logic         and_ratna,
  input  logic         or_ratna,
  input  logic         cmp_ratna,
  input  logic         lda_imm,
  input  logic         sta_imm,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry
);

  localparam logic [W:0] ONE_EXT = {{W{1'b0}}, 1'b1};

  alu_op_t    op;
  logic [W:0] sum;
  logic [W:0] diff;

  // Select the operation, form both 9-bit arithmetic results and pick the output.
  always_comb begin
    op     = alu_select(sub_add, xor_ratna, and_ratna, or_ratna,
                        cmp_ratna, lda_imm, sta_imm);
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_SUB: begin result = diff[W-1:0]; carry = diff[W]; end
      ALU_XOR: result = a ^ b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_CMP: begin result = a; carry = diff[W]; end
      ALU_LDI: result = imm;
      ALU_STI: result = a;
      default: begin result = sum[W-1:0]; carry = sum[W]; end
    endcase
    zero = (op == ALU_CMP) ? (diff[W-1:0] == '0) : (result == '0);
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 W-bus datapath: executes control-word strobes from the sequencer.
// Holds PC, MAR, RAM, IR, ACC, B, OUT and flags, plus a program-load port.
module sap_datapath #(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              pc_out_en,
  input  logic              low_ld_mar,
  input  logic              low_mem_out_en,
  input  logic              low_ld_ir,
  input  logic              low_ir_out_en,
  input  logic              low_ld_acc,
  input  logic              acc_out_en,
  input  logic              subadd_out_en,
  input  logic              sub_add,
  input  logic              xor_ratna,
  input  logic              and_ratna,
  input  logic              or_ratna,
  input  logic              cmp_ratna,
  input  logic              lda_imm,
  input  logic              sta_imm,
  input  logic              low_ld_b_reg,
  input  logic              low_ld_out_reg,
  input  logic              low_halt,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [3:0]        op_code,
  output logic [DATA_W-1:0] out_reg,
  output logic [DATA_W-1:0] w_bus,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              bus_err
);

  import sap_pkg::*;

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic [4:0]        drivers;
  logic              sta_wr;

  assign op_code = ir[DATA_W-1 -: 4];
  assign imm     = {{(DATA_W-4){1'b0}}, ir[3:0]};

  sap_alu #(.W(DATA_W)) u_alu (
    .a         (acc),
    .b         (b_reg),
    .imm       (imm),
    .sub_add   (sub_add),
    .xor_ratna (xor_ratna),
    .and_ratna (and_ratna),
    .or_ratna  (or_ratna),
    .cmp_ratna (cmp_ratna),
    .lda_imm   (lda_imm),
    .sta_imm   (sta_imm),
    .result    (alu_result),
    .zero      (alu_zero),
    .carry     (alu_carry)
  );

  // Bus mux: priority ALU > ACC > IR > RAM > PC; flag any multi-driver cycle.
  always_comb begin
    drivers = {subadd_out_en, acc_out_en, ~low_ir_out_en, ~low_mem_out_en, pc_out_en};
    w_bus   = '0;
    if (subadd_out_en)        w_bus = alu_result;
    else if (acc_out_en)      w_bus = acc;
    else if (!low_ir_out_en)  w_bus = imm;
    else if (!low_mem_out_en) w_bus = ram[mar];
    else if (pc_out_en)       w_bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    bus_err = (drivers & (drivers - 5'd1)) != 5'd0;
    sta_wr  = subadd_out_en &&
              (alu_select(sub_add, xor_ratna, and_ratna, or_ratna,
                          cmp_ratna, lda_imm, sta_imm) == ALU_STI);
  end

  // Register file: reset beats everything, halt freezes, otherwise strobed loads.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      acc        <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (low_halt) begin
      if (inc)             pc      <= pc + PC_ONE;
      if (!low_ld_mar)     mar     <= w_bus[ADDR_W-1:0];
      if (!low_ld_ir)      ir      <= w_bus;
      if (!low_ld_acc)     acc     <= w_bus;
      if (!low_ld_b_reg)   b_reg   <= w_bus;
      if (!low_ld_out_reg) out_reg <= w_bus;
      if (subadd_out_en) begin
        zero_flag  <= alu_zero;
        carry_flag <= alu_carry;
      end
    end
  end

  // RAM write: program load (allowed during reset) beats a store-immediate.
  always_ff @(posedge clk) begin
    if (low_halt) begin
      if (load_en)            ram[load_addr] <= load_data;
      else if (!clr && sta_wr) ram[mar]      <= acc;
    end
  end

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: a small software sequencer runs programs
// loaded through the load port and each scenario checks hand-computed values.
module tb_sap_datapath;

  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       clr, inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir;
  logic       low_ir_out_en, low_ld_acc, acc_out_en, subadd_out_en;
  logic       sub_add, xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm;
  logic       low_ld_b_reg, low_ld_out_reg, low_halt, load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] op_code;
  logic [7:0] out_reg, w_bus;
  logic       zero_flag, carry_flag, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  sap_datapath dut (
    .clk(clk), .clr(clr), .inc(inc), .pc_out_en(pc_out_en),
    .low_ld_mar(low_ld_mar), .low_mem_out_en(low_mem_out_en),
    .low_ld_ir(low_ld_ir), .low_ir_out_en(low_ir_out_en),
    .low_ld_acc(low_ld_acc), .acc_out_en(acc_out_en),
    .subadd_out_en(subadd_out_en), .sub_add(sub_add), .xor_ratna(xor_ratna),
    .and_ratna(and_ratna), .or_ratna(or_ratna), .cmp_ratna(cmp_ratna),
    .lda_imm(lda_imm), .sta_imm(sta_imm), .low_ld_b_reg(low_ld_b_reg),
    .low_ld_out_reg(low_ld_out_reg), .low_halt(low_halt), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .op_code(op_code),
    .out_reg(out_reg), .w_bus(w_bus), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .bus_err(bus_err)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    inc = 1'b0; pc_out_en = 1'b0; low_ld_mar = 1'b1; low_mem_out_en = 1'b1;
    low_ld_ir = 1'b1; low_ir_out_en = 1'b1; low_ld_acc = 1'b1;
    acc_out_en = 1'b0; subadd_out_en = 1'b0; sub_add = 1'b0;
    xor_ratna = 1'b0; and_ratna = 1'b0; or_ratna = 1'b0; cmp_ratna = 1'b0;
    lda_imm = 1'b0; sta_imm = 1'b0; low_ld_b_reg = 1'b1; low_ld_out_reg = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Drive one bus source alone and return the bus value: 0 PC, 1 ACC, 2 IR, 3 RAM[MAR].
  task automatic peek(input int src, output logic [7:0] v);
    case (src)
      0: pc_out_en = 1'b1;
      1: acc_out_en = 1'b1;
      2: low_ir_out_en = 1'b0;
      default: low_mem_out_en = 1'b0;
    endcase
    #1 v = w_bus;
    idle();
    #1;
  endtask

  // Six T-states of one instruction, strobes chosen from the known opcode.
  task automatic run_instr(input logic [3:0] op);
    pc_out_en = 1'b1; low_ld_mar = 1'b0; step();            // t5
    inc = 1'b1; step();                                      // t4
    low_mem_out_en = 1'b0; low_ld_ir = 1'b0; step();         // t3
    if (op == OUT) begin                                     // t2
      acc_out_en = 1'b1; low_ld_out_reg = 1'b0;
    end else if (op != LDI) begin
      low_ir_out_en = 1'b0; low_ld_mar = 1'b0;
    end
    step();
    if (op == LDA) begin                                     // t1
      low_mem_out_en = 1'b0; low_ld_acc = 1'b0;
    end else if (op inside {ADD, SUB, XOR, AND, OR, CMP}) begin
      low_mem_out_en = 1'b0; low_ld_b_reg = 1'b0;
    end
    step();
    if (op inside {ADD, SUB, XOR, AND, OR, CMP, LDI}) begin  // t0
      subadd_out_en = 1'b1; low_ld_acc = 1'b0;
      sub_add   = (op == SUB);
      xor_ratna = (op == XOR);
      and_ratna = (op == AND);
      or_ratna  = (op == OR);
      cmp_ratna = (op == CMP);
      lda_imm   = (op == LDI);
    end else if (op == STI) begin
      subadd_out_en = 1'b1; sta_imm = 1'b1;
    end
    step();
  endtask

  task automatic begin_reset();
    idle(); low_halt = 1'b1; load_en = 1'b0; clr = 1'b1;
    step();
  endtask

  task automatic end_reset();
    clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] v;
    begin_reset();
    load_word(4'h0, 8'h1E);
    load_word(4'hE, 8'h07);
    end_reset();
    peek(0, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", v); end
    peek(1, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL rst_acc: got %h want 00", v); end
    peek(2, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL rst_ir: got %h want 00", v); end
    peek(3, v); n_cmp++; if (v !== 8'h1E) begin n_err++; $display("FAIL rst_ram0: got %h want 1e", v); end
    n_cmp++; if (op_code !== 4'h0) begin n_err++; $display("FAIL rst_opcode: got %h want 0", op_code); end
    n_cmp++; if (out_reg !== 8'h00) begin n_err++; $display("FAIL rst_out: got %h want 00", out_reg); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {zero_flag, carry_flag}); end
    n_cmp++; if ({bus_err, w_bus} !== 9'h000) begin n_err++; $display("FAIL idle_bus: got %h want 000", {bus_err, w_bus}); end
    run_instr(LDA);
    peek(1, v); n_cmp++; if (v !== 8'h07) begin n_err++; $display("FAIL lda_acc: got %h want 07", v); end
    n_cmp++; if (op_code !== 4'h1) begin n_err++; $display("FAIL lda_opcode: got %h want 1", op_code); end
    peek(0, v); n_cmp++; if (v !== 8'h01) begin n_err++; $display("FAIL lda_pc: got %h want 01", v); end
  endtask

  task automatic test_add_sub();
    logic [7:0] v;
    begin_reset();
    load_word(4'h0, 8'h1E); load_word(4'h1, 8'h2F);
    load_word(4'h2, 8'h1D); load_word(4'h3, 8'h3C);
    load_word(4'hC, 8'h05); load_word(4'hD, 8'h05);
    load_word(4'hE, 8'hF0); load_word(4'hF, 8'h20);
    end_reset();
    run_instr(LDA);
    run_instr(ADD);
    peek(1, v); n_cmp++; if (v !== 8'h10) begin n_err++; $display("FAIL add_acc: got %h want 10", v); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b01) begin n_err++; $display("FAIL add_flags(zc): got %b want 01", {zero_flag, carry_flag}); end
    run_instr(LDA);
    run_instr(SUB);
    peek(1, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL sub_acc: got %h want 00", v); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b11) begin n_err++; $display("FAIL sub_flags(zc): got %b want 11", {zero_flag, carry_flag}); end
  endtask

  task automatic test_cmp();
    logic [7:0] v;
    begin_reset();
    load_word(4'h0, 8'h1E); load_word(4'h1, 8'h8F); load_word(4'h2, 8'h8E);
    load_word(4'hE, 8'h03); load_word(4'hF, 8'h09);
    end_reset();
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b00) begin n_err++; $display("FAIL rst_flags_clear: got %b want 00", {zero_flag, carry_flag}); end
    run_instr(LDA);
    run_instr(CMP);
    peek(1, v); n_cmp++; if (v !== 8'h03) begin n_err++; $display("FAIL cmp_lt_acc: got %h want 03", v); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b00) begin n_err++; $display("FAIL cmp_lt_flags(zc): got %b want 00", {zero_flag, carry_flag}); end
    run_instr(CMP);
    peek(1, v); n_cmp++; if (v !== 8'h03) begin n_err++; $display("FAIL cmp_eq_acc: got %h want 03", v); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b11) begin n_err++; $display("FAIL cmp_eq_flags(zc): got %b want 11", {zero_flag, carry_flag}); end
  endtask

  task automatic test_sta_out();
    logic [7:0] v;
    begin_reset();
    load_word(4'h0, 8'h1E); load_word(4'h1, 8'hAA); load_word(4'h2, 8'h40);
    load_word(4'h3, 8'h90); load_word(4'h4, 8'h1A); load_word(4'hE, 8'h5C);
    end_reset();
    run_instr(LDA);
    run_instr(STI);
    peek(3, v); n_cmp++; if (v !== 8'h5C) begin n_err++; $display("FAIL sta_ram_a: got %h want 5c", v); end
    n_cmp++; if (out_reg !== 8'h00) begin n_err++; $display("FAIL out_before: got %h want 00", out_reg); end
    run_instr(OUT);
    n_cmp++; if (out_reg !== 8'h5C) begin n_err++; $display("FAIL out_reg: got %h want 5c", out_reg); end
    run_instr(LDI);
    peek(1, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL ldi_acc: got %h want 00", v); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b10) begin n_err++; $display("FAIL ldi_flags(zc): got %b want 10", {zero_flag, carry_flag}); end
    run_instr(LDA);
    peek(1, v); n_cmp++; if (v !== 8'h5C) begin n_err++; $display("FAIL lda_stored: got %h want 5c", v); end
    n_cmp++; if (out_reg !== 8'h5C) begin n_err++; $display("FAIL out_hold: got %h want 5c", out_reg); end
  endtask

  task automatic test_pc_halt();
    logic [7:0] v;
    begin_reset();
    load_word(4'h0, 8'h77);
    end_reset();
    for (int i = 0; i < 4; i++) begin
      low_halt = 1'b0; inc = 1'b1; low_mem_out_en = 1'b0; low_ld_acc = 1'b0;
      low_ld_ir = 1'b0; low_ld_b_reg = 1'b0; low_ld_out_reg = 1'b0; low_ld_mar = 1'b0;
      load_en = 1'b1; load_addr = 4'h0; load_data = 8'h11;
      #1;
      n_cmp++; if (w_bus !== 8'h77) begin n_err++; $display("FAIL halt_bus_track[%0d]: got %h want 77", i, w_bus); end
      step();
    end
    low_halt = 1'b1; load_en = 1'b0;
    peek(0, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL halt_pc: got %h want 00", v); end
    peek(1, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL halt_acc: got %h want 00", v); end
    peek(2, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL halt_ir: got %h want 00", v); end
    peek(3, v); n_cmp++; if (v !== 8'h77) begin n_err++; $display("FAIL halt_ram: got %h want 77", v); end
    n_cmp++; if ({op_code, out_reg} !== 12'h000) begin n_err++; $display("FAIL halt_op_out: got %h want 000", {op_code, out_reg}); end
    low_mem_out_en = 1'b0; low_ld_acc = 1'b0; step();
    peek(1, v); n_cmp++; if (v !== 8'h77) begin n_err++; $display("FAIL unhalt_acc: got %h want 77", v); end
    for (int i = 0; i < 15; i++) begin
      inc = 1'b1; step();
    end
    peek(0, v); n_cmp++; if (v !== 8'h0F) begin n_err++; $display("FAIL pc_f: got %h want 0f", v); end
    inc = 1'b1; step();
    peek(0, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL pc_wrap: got %h want 00", v); end
  endtask

  task automatic test_bus_conflict();
    begin_reset();
    load_word(4'h0, 8'h1E); load_word(4'hE, 8'h3C);
    end_reset();
    run_instr(LDA);
    load_word(4'hE, 8'hA5);
    acc_out_en = 1'b1; low_mem_out_en = 1'b0; #1;
    n_cmp++; if ({bus_err, w_bus} !== 9'h13C) begin n_err++; $display("FAIL conflict_acc_ram: got %h want 13c", {bus_err, w_bus}); end
    idle(); low_mem_out_en = 1'b0; #1;
    n_cmp++; if ({bus_err, w_bus} !== 9'h0A5) begin n_err++; $display("FAIL single_ram: got %h want 0a5", {bus_err, w_bus}); end
    idle(); pc_out_en = 1'b1; low_ir_out_en = 1'b0; #1;
    n_cmp++; if ({bus_err, w_bus} !== 9'h10E) begin n_err++; $display("FAIL conflict_ir_pc: got %h want 10e", {bus_err, w_bus}); end
    idle(); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    clr = 1'b1; low_halt = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_add_sub();
    test_cmp();
    test_sta_out();
    test_pc_halt();
    test_bus_conflict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
